// File: rtl/lcd_refresh_requester.sv
// lcd_refresh_requester
//
// Consumer end of the change-flag interface fed by the per-signal change
// detectors of the 16x2 LCD path. Rising edges on the change flags are
// latched as pending refresh events. A round-robin arbiter picks one pending
// event at a time and hands it to the LCD controller over a req/ack/done
// handshake. After each completed refresh, a minimum idle gap is enforced.
//
// Parameters:
//   NUM_SRC        number of change-flag sources (>= 2)
//   GAP_CYCLES     idle cycles after each completed refresh (0 = no gap)
//   TIMEOUT_CYCLES ack/done abort limit, only used with REFRESH_TIMEOUT_EN
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-low reset
//   change_in  change flags, one per source (may stay high for many cycles)
//   ack        LCD controller accepted the current request
//   done       one-cycle pulse, LCD controller finished the refresh
//   req        refresh request level
//   req_id     source index of the current request
//   busy       high whenever the FSM is not idle
//   pending    latched events not yet granted
//   lost       sticky: an event arrived on a source that was already pending
//   timeout    one-cycle abort pulse (constant 0 without the option)
//
// Optional feature, enabled by defining the macro REFRESH_TIMEOUT_EN:
// aborts a request whose ack/done does not arrive within TIMEOUT_CYCLES.
module lcd_refresh_requester #(
  parameter int NUM_SRC        = 4,
  parameter int GAP_CYCLES     = 1000,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_SRC-1:0]         change_in,
  input  logic                       ack,
  input  logic                       done,
  output logic                       req,
  output logic [$clog2(NUM_SRC)-1:0] req_id,
  output logic                       busy,
  output logic [NUM_SRC-1:0]         pending,
  output logic                       lost,
  output logic                       timeout
);

  localparam int ID_W  = $clog2(NUM_SRC);
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [ID_W-1:0]  PTR_INIT = ID_W'(NUM_SRC - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    BUSY,
    HOLDOFF
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [NUM_SRC-1:0] change_d;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] clr_mask;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    grant_idx;
  logic               found;
  logic               grant_en;
  logic               timeout_next;
  logic               tmo_hit;
  logic [GAP_W-1:0]   gap_cnt;

  // Where a finished (or aborted) transaction goes: the gap is skipped
  // entirely when no gap is configured.
  function automatic state_t after_done();
    if (GAP_CYCLES == 0) begin
      return IDLE;
    end else begin
      return HOLDOFF;
    end
  endfunction

  // Source index reached by stepping 'offset' positions past 'base',
  // wrapping around the number of sources.
  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base,
                                               input int offset);
    int sum;
    sum = (int'(base) + offset) % NUM_SRC;
    return ID_W'(sum);
  endfunction

  assign rise = change_in & ~change_d;
  assign req  = (state == REQ);
  assign busy = (state != IDLE);

  // Round-robin search starts just after the last granted index, so the
  // source that was served most recently has the lowest priority.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int off = 1; off <= NUM_SRC; off++) begin
      if (!found && pending[rr_index(ptr, off)]) begin
        found     = 1'b1;
        grant_idx = rr_index(ptr, off);
      end
    end
  end

  // Next-state logic. In REQ, an ack that arrives together with done
  // finishes the transaction right away. An ack or done that arrives in
  // any other state is ignored. The awaited event always wins over an
  // abort that happens in the same cycle.
  always_comb begin
    state_next   = state;
    grant_en     = 1'b0;
    timeout_next = 1'b0;
    clr_mask     = '0;
    case (state)
      IDLE: begin
        if (found) begin
          grant_en   = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        if (ack) begin
          if (done) begin
            state_next = after_done();
          end else begin
            state_next = BUSY;
          end
        end else if (tmo_hit) begin
          state_next   = after_done();
          timeout_next = 1'b1;
        end
      end
      BUSY: begin
        if (done) begin
          state_next = after_done();
        end else if (tmo_hit) begin
          state_next   = after_done();
          timeout_next = 1'b1;
        end
      end
      HOLDOFF: begin
        if (gap_cnt == GAP_LAST) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (grant_en) begin
      clr_mask[grant_idx] = 1'b1;
    end
  end

  // State and event bookkeeping. A rise on a source that is being granted
  // in the same cycle keeps that source pending, so the new event is
  // served later. A rise on a source that is already pending is merged
  // with the existing event and recorded in the sticky lost flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      change_d <= '0;
      pending  <= '0;
      lost     <= 1'b0;
      req_id   <= '0;
      ptr      <= PTR_INIT;
      gap_cnt  <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_next;
      change_d <= change_in;
      pending  <= (pending & ~clr_mask) | rise;
      if (|(rise & pending)) begin
        lost <= 1'b1;
      end
      if (grant_en) begin
        req_id <= grant_idx;
        ptr    <= grant_idx;
      end
      if ((state == HOLDOFF) && (state_next == HOLDOFF)) begin
        gap_cnt <= gap_cnt + 1'b1;
      end else begin
        gap_cnt <= '0;
      end
      timeout <= timeout_next;
    end
  end

`ifdef REFRESH_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt;

  // Wait-time counter. It restarts on every state change, so REQ and BUSY
  // each get their own full budget. The abort fires on the
  // TIMEOUT_CYCLES-th cycle spent waiting in the same state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (((state == REQ) || (state == BUSY)) && (state_next == state)) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end

  assign tmo_hit = ((state == REQ) || (state == BUSY)) && (tmo_cnt == TMO_LAST);
`else
  logic [31:0] unused_timeout_cfg;

  assign tmo_hit            = 1'b0;
  assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
`endif

endmodule

// File: tb/tb_lcd_refresh_requester.sv
// tb_lcd_refresh_requester
//
// Self-checking bench for lcd_refresh_requester (NUM_SRC=4, GAP_CYCLES=4,
// TIMEOUT_CYCLES=20). A transaction-level reference model tracks pending
// events, the round-robin pointer and the refresh phase as a countdown.
// After every clock, the model is compared against all DUT outputs.
// Directed scenarios are followed by a long randomized run that includes
// stray handshakes and occasional resets.
module tb_lcd_refresh_requester;

  localparam int NS  = 4;
  localparam int GAP = 4;
  localparam int TMO = 20;
`ifdef REFRESH_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [NS-1:0] change_in;
  logic          ack;
  logic          done;
  logic          req;
  logic [1:0]    req_id;
  logic          busy;
  logic [NS-1:0] pending;
  logic          lost;
  logic          timeout;

  int errors = 0;
  int checks = 0;

  // Reference model state. The model is busy while a transaction or its
  // gap is in progress. m_gap counts the remaining gap cycles.
  bit [NS-1:0] m_pending;
  bit [NS-1:0] m_prev;
  bit          m_lost;
  bit          m_req;
  bit          m_busy;
  bit          m_tmo;
  int          m_id;
  int          m_ptr;
  int          m_gap;
  int          m_age;

  int grant_log[$];
  bit req_seen;

  bit auto_resp;
  bit stray_en;
  int resp;
  int ack_cnt;
  int done_cnt;
  int ack_lo;
  int ack_hi;
  int done_lo;
  int done_hi;

  lcd_refresh_requester #(
    .NUM_SRC(NS),
    .GAP_CYCLES(GAP),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .change_in(change_in),
    .ack(ack),
    .done(done),
    .req(req),
    .req_id(req_id),
    .busy(busy),
    .pending(pending),
    .lost(lost),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Ends the run if something keeps it from finishing.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, got, want);
    end
  endtask

  function automatic int logAt(input int i);
    if (i < grant_log.size()) begin
      return grant_log[i];
    end
    return -1;
  endfunction

  // Ends a transaction: it enters the gap, or becomes free at once when no gap is configured.
  task automatic modelFinish();
    m_req = 1'b0;
    if (GAP > 0) begin
      m_gap = GAP;
    end else begin
      m_busy = 1'b0;
    end
  endtask

  // Counts one more cycle of waiting and aborts once the limit is reached.
  task automatic modelAge();
    m_age++;
    if (TMO_EN && (m_age == TMO)) begin
      m_tmo = 1'b1;
      modelFinish();
    end
  endtask

  // One clock edge of the behavioural model, using the inputs sampled at that edge.
  task automatic modelEdge();
    bit [NS-1:0] rise;
    bit [NS-1:0] clr;
    bit          picked;
    if (!reset) begin
      m_pending = '0;
      m_prev    = '0;
      m_lost    = 1'b0;
      m_req     = 1'b0;
      m_busy    = 1'b0;
      m_tmo     = 1'b0;
      m_id      = 0;
      m_ptr     = NS - 1;
      m_gap     = 0;
      m_age     = 0;
      return;
    end
    rise   = change_in & ~m_prev;
    m_prev = change_in;
    clr    = '0;
    picked = 1'b0;
    m_tmo  = 1'b0;
    if (!m_busy) begin
      for (int k = 1; k <= NS; k++) begin
        int c;
        c = (m_ptr + k) % NS;
        if (!picked && m_pending[c]) begin
          picked = 1'b1;
          m_id   = c;
        end
      end
      if (picked) begin
        m_ptr      = m_id;
        clr[m_id]  = 1'b1;
        m_busy     = 1'b1;
        m_req      = 1'b1;
        m_age      = 0;
      end
    end else if (m_gap > 0) begin
      m_gap--;
      if (m_gap == 0) begin
        m_busy = 1'b0;
      end
    end else if (m_req) begin
      if (ack) begin
        m_req = 1'b0;
        m_age = 0;
        if (done) begin
          modelFinish();
        end
      end else begin
        modelAge();
      end
    end else begin
      if (done) begin
        modelFinish();
      end else begin
        modelAge();
      end
    end
    if (|(rise & m_pending)) begin
      m_lost = 1'b1;
    end
    m_pending = (m_pending & ~clr) | rise;
  endtask

  // Advances one clock, updates the model, then compares every output just after the edge.
  task automatic applyStimulus();
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput("req", 32'(req), 32'(m_req));
    checkOutput("busy", 32'(busy), 32'(m_busy));
    checkOutput("req_id", 32'(req_id), 32'(m_id));
    checkOutput("pending", 32'(pending), 32'(m_pending));
    checkOutput("lost", 32'(lost), 32'(m_lost));
    checkOutput("timeout", 32'(timeout), 32'(m_tmo));
    if (req && !req_seen) begin
      grant_log.push_back(int'(req_id));
    end
    req_seen = req;
  endtask

  // LCD controller stand-in: acks, then pulses done after the configured
  // delays. It can also inject stray ack/done pulses that the DUT must ignore.
  task automatic driveLcd();
    ack  = 1'b0;
    done = 1'b0;
    if ((resp == 1) && !m_req) begin
      resp = 0;
    end
    if ((resp == 2) && (!m_busy || (m_gap > 0))) begin
      resp = 0;
    end
    if (!auto_resp) begin
      return;
    end
    if ((resp == 0) && m_req) begin
      resp    = 1;
      ack_cnt = $urandom_range(ack_hi, ack_lo);
    end
    if (resp == 1) begin
      if (ack_cnt == 0) begin
        ack = 1'b1;
        if (stray_en && ($urandom_range(0, 7) == 0)) begin
          done = 1'b1;
          resp = 0;
        end else begin
          resp     = 2;
          done_cnt = $urandom_range(done_hi, done_lo);
        end
      end else begin
        ack_cnt--;
        if (stray_en && ($urandom_range(0, 7) == 0)) begin
          done = 1'b1;
        end
      end
    end else if (resp == 2) begin
      if (done_cnt == 0) begin
        done = 1'b1;
        resp = 0;
      end else begin
        done_cnt--;
      end
    end else if (stray_en && ($urandom_range(0, 15) == 0)) begin
      if ($urandom_range(0, 1) == 0) begin
        ack = 1'b1;
      end else begin
        done = 1'b1;
      end
    end
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) begin
      driveLcd();
      applyStimulus();
    end
  endtask

  task automatic setResp(input int alo, input int ahi, input int dlo, input int dhi, input bit stray);
    ack_lo   = alo;
    ack_hi   = ahi;
    done_lo  = dlo;
    done_hi  = dhi;
    stray_en = stray;
  endtask

  task automatic doReset();
    reset     = 1'b0;
    change_in = '0;
    ack       = 1'b0;
    done      = 1'b0;
    applyStimulus();
    applyStimulus();
    reset = 1'b1;
    resp  = 0;
    grant_log.delete();
  endtask

  task automatic waitReq(input int bound);
    int n;
    n = 0;
    while (!req && (n < bound)) begin
      applyStimulus();
      n++;
    end
    checkOutput("wait_req", 32'(req), 32'd1);
  endtask

  initial begin
    int n;
    reset     = 1'b0;
    change_in = '0;
    ack       = 1'b0;
    done      = 1'b0;
    auto_resp = 1'b0;
    resp      = 0;
    req_seen  = 1'b0;
    setResp(0, 0, 0, 0, 1'b0);

    $display("[TB] reset sequence");
    doReset();
    applyStimulus();
    checkOutput("rst_req", 32'(req), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_pending", 32'(pending), 32'd0);
    checkOutput("rst_lost", 32'(lost), 32'd0);
    checkOutput("rst_req_id", 32'(req_id), 32'd0);

    $display("[TB] long flag on source 2");
    change_in = 4'b0100;
    setResp(2, 2, 9, 9, 1'b0);
    auto_resp = 1'b1;
    runCycles(100);
    change_in = '0;
    runCycles(20);
    checkOutput("t2_req_count", grant_log.size(), 1);
    checkOutput("t2_req_id", logAt(0), 2);
    checkOutput("t2_idle", 32'(busy), 32'd0);

    $display("[TB] round-robin ordering");
    doReset();
    setResp(3, 3, 5, 5, 1'b0);
    auto_resp = 1'b1;
    change_in = 4'b1001;
    runCycles(2);
    change_in = 4'b0000;
    runCycles(1);
    change_in = 4'b0011;
    runCycles(100);
    change_in = '0;
    runCycles(10);
    checkOutput("t3_count", grant_log.size(), 4);
    checkOutput("t3_id0", logAt(0), 0);
    checkOutput("t3_id1", logAt(1), 1);
    checkOutput("t3_id2", logAt(2), 3);
    checkOutput("t3_id3", logAt(3), 0);
    checkOutput("t3_lost", 32'(lost), 32'd0);

    $display("[TB] merged event on pending source");
    doReset();
    auto_resp = 1'b0;
    change_in = 4'b0100;
    runCycles(2);
    change_in = 4'b0110;
    runCycles(1);
    change_in = 4'b0100;
    runCycles(1);
    change_in = 4'b0110;
    runCycles(1);
    checkOutput("t4_lost_set", 32'(lost), 32'd1);
    checkOutput("t4_pend1", 32'(pending[1]), 32'd1);
    setResp(1, 2, 2, 4, 1'b0);
    auto_resp = 1'b1;
    runCycles(60);
    checkOutput("t4_lost_sticky", 32'(lost), 32'd1);
    checkOutput("t4_count", grant_log.size(), 2);
    checkOutput("t4_id0", logAt(0), 2);
    checkOutput("t4_id1", logAt(1), 1);

    $display("[TB] reset while busy");
    doReset();
    auto_resp = 1'b0;
    change_in = 4'b1000;
    waitReq(10);
    ack = 1'b1;
    applyStimulus();
    ack = 1'b0;
    applyStimulus();
    applyStimulus();
    applyStimulus();
    checkOutput("t5_busy_pre", 32'(busy), 32'd1);
    checkOutput("t5_req_pre", 32'(req), 32'd0);
    change_in = '0;
    reset     = 1'b0;
    applyStimulus();
    checkOutput("t5_rst_req", 32'(req), 32'd0);
    checkOutput("t5_rst_busy", 32'(busy), 32'd0);
    checkOutput("t5_rst_pending", 32'(pending), 32'd0);
    reset = 1'b1;
    done  = 1'b1;
    applyStimulus();
    done = 1'b0;
    applyStimulus();
    checkOutput("t5_done_ignored", 32'(busy), 32'd0);
    grant_log.delete();
    change_in = 4'b0010;
    setResp(0, 3, 0, 5, 1'b0);
    auto_resp = 1'b1;
    runCycles(40);
    checkOutput("t5_count", grant_log.size(), 1);
    checkOutput("t5_id", logAt(0), 1);
    checkOutput("t5_idle", 32'(busy), 32'd0);

`ifdef REFRESH_TIMEOUT_EN
    $display("[TB] request abort");
    doReset();
    auto_resp = 1'b0;
    change_in = 4'b0010;
    waitReq(10);
    n = 0;
    while (!timeout && (n < 40)) begin
      applyStimulus();
      n++;
    end
    checkOutput("t6_tmo_cycles", n, TMO);
    checkOutput("t6_req_drop", 32'(req), 32'd0);
    checkOutput("t6_holdoff_busy", 32'(busy), 32'd1);
    applyStimulus();
    checkOutput("t6_tmo_single", 32'(timeout), 32'd0);
    runCycles(GAP + 2);
    checkOutput("t6_idle", 32'(busy), 32'd0);
    checkOutput("t6_not_requeued", 32'(pending), 32'd0);
`endif

    $display("[TB] randomized run");
    doReset();
    setResp(0, 4, 0, 6, 1'b1);
    auto_resp = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < NS; b++) begin
        if ($urandom_range(0, 11) == 0) begin
          change_in[b] = ~change_in[b];
        end
      end
      reset = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      driveLcd();
      applyStimulus();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_refresh_requester.md
Name: lcd_refresh_requester

Overview:
- Consumer end of the change-flag interface produced by the per-signal change detectors in the pantalla_LCD_16x2 path.
- Detects rising edges on NUM_SRC change flags and latches each as a pending refresh event.
- Arbitrates pending events round-robin and issues one refresh request at a time to the LCD controller over a req/ack/done handshake.
- Enforces a minimum gap between refreshes.

Parameters:
- NUM_SRC, 4: number of change-flag sources; must be >= 2.
- GAP_CYCLES, 1000: idle cycles enforced after each completed refresh; 0 means no gap.
- TIMEOUT_CYCLES, 50000000: abort limit for ack/done; used only with REFRESH_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low.
- change_in  in  NUM_SRC  change flags; each may stay high for many cycles.
- ack  in  1  LCD controller accepted the current request.
- done  in  1  one-cycle pulse: LCD controller finished the refresh.
- req  out  1  refresh request, level.
- req_id  out  $clog2(NUM_SRC)  source index of the current request.
- busy  out  1  FSM not in IDLE.
- pending  out  NUM_SRC  latched, not-yet-granted events.
- lost  out  1  sticky: an event arrived on a source already pending.
- timeout  out  1  one-cycle abort pulse; constant 0 without REFRESH_TIMEOUT_EN.

Behaviour:
- Reset (reset==0 at a clk edge):
  - FSM goes to IDLE.
  - req, busy, pending, lost, timeout, internal change_d and counters all go to 0.
  - req_id goes to 0.
  - Round-robin pointer goes to NUM_SRC-1, so index 0 wins first.
  - Reset mid-transaction drops req at that same edge; no done/ack is awaited afterwards.
- Edge detect: rise[i] = change_in[i] & ~change_d[i], with change_d registered every cycle.
  - A flag already high when reset is released counts as one event.
- Pending:
  - rise[i] sets pending[i].
  - pending[i] is cleared on the edge where source i is granted.
  - Simultaneous rise[i] and grant of i: set wins; the event stays pending.
  - rise[i] while pending[i] is already 1: event merged and lost set to 1; lost holds until reset.
- Arbitration: round-robin. The first set pending bit searching upward from pointer+1 with wrap-around wins; pointer is updated to the granted index.
- State IDLE:
  - busy=0.
  - If |pending: grant, load req_id, set req=1, go to REQ.
  - Latency: change_in first sampled high at edge k -> pending set after edge k -> req high after edge k+1.
- State REQ:
  - req=1 and req_id held stable until ack is sampled high.
  - On ack: req=0 at that edge, go to BUSY.
- State BUSY: wait for done.
  - On done, go to HOLDOFF, or straight to IDLE if GAP_CYCLES==0.
  - done seen in the same cycle as ack while in REQ: go directly to HOLDOFF/IDLE.
- State HOLDOFF: counter runs 0..GAP_CYCLES-1, then IDLE, giving exactly GAP_CYCLES cycles. New events keep latching during HOLDOFF.
- ack or done outside its expected state is ignored.
- Counter widths are $clog2(limit+1); no wrap-around is possible before the terminal count.

Optional Feature:
- Macro: REFRESH_TIMEOUT_EN.
- Defined:
  - A counter runs in REQ and BUSY and clears on every state change.
  - Reaching TIMEOUT_CYCLES without the awaited ack/done: req=0, timeout=1 for one cycle, go to HOLDOFF (or IDLE if GAP_CYCLES==0).
  - The aborted event is not re-queued.
- Undefined: no counter; the FSM waits indefinitely; timeout is tied to 0.

Test Plan:
- Reset sequence with change_in=0: after the reset release edge, req=0, busy=0, pending=0, lost=0, req_id=0.
- change_in[2] held high 100 cycles; ack 3 cycles after req; done 10 cycles later; GAP_CYCLES=4 -> exactly one request with req_id=2, busy for the whole transaction, IDLE after 4 gap cycles.
- change_in[0] and change_in[3] rising in the same cycle -> requests issued in order id 0 then id 3; a later rise on 0 and 1 together -> id 1 first (round-robin after 0).
- While source 1 is pending and not granted, toggle change_in[1] low then high -> lost=1 and stays 1; only one request issued for id 1.
- Assert reset low while in BUSY -> req/busy/pending=0 at that edge; a subsequent done pulse is ignored; a new event is served normally.
- With REFRESH_TIMEOUT_EN and TIMEOUT_CYCLES=20, never assert ack -> req drops and timeout pulses exactly 20 cycles after entering REQ; the FSM passes through HOLDOFF to IDLE.
